mem_interface: RTL and testbench

//  Memory-side partner of the microcontroller core: consumes Enable/RW/Address/write data

---
 rtl/mem_interface_pkg.sv | 20 ++
 rtl/mem_interface_mem_array.sv | 35 +++
 rtl/mem_interface.sv | 141 ++++++++++++++
 tb/tb_mem_interface.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_interface_pkg.sv
// Shared definitions for the memory interface slice.
// Contents:
//   state_t   - FSM state encoding (IDLE / ACCESS / DONE)
//   RW_READ   - value of RW that requests a read
//   RW_WRITE  - value of RW that requests a write
//   WAIT_W    - width of the wait-state counter
package mem_interface_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_interface_mem_array.sv
// mem_array: single-port RAM with a clocked write port and a combinational
// read port. The owning FSM registers the read data on the access edge, so
// the read path is still fully synchronous at the block boundary.
// Contents are intentionally not reset.
// Ports:
//   clk      in  1           rising-edge clock
//   i_we     in  1           write enable
//   i_addr   in  DEPTH_LOG2  word address
//   i_wdata  in  DATA_W      write data
//   o_rdata  out DATA_W      data at i_addr
module mem_array #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**DEPTH_LOG2)-1];

    // Storage write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else begin
            r_mem[i_addr] <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_interface.sv
// mem_interface: memory-side partner of the microcontroller core.
// Captures a request (Enable/RW/Address/DataIn), waits WAIT_STATES cycles,
// performs the RAM access, then holds MFC high until Enable is released
// (four-phase handshake).
// Ports:
//   clk        in  1       rising-edge clock
//   reset      in  1       asynchronous active-low reset
//   Enable     in  1       request level, held until MFC is seen
//   RW         in  1       1 = read, 0 = write
//   Address    in  ADDR_W  word address
//   DataIn     in  DATA_W  write data
//   DataToMDR  out DATA_W  registered read data
//   MFC        out 1       memory function complete
//   addr_err   out 1       out-of-range request, valid with MFC
//   busy       out 1       FSM not in IDLE
module mem_interface
    import mem_interface_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Enable,
    input  logic              RW,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataToMDR,
    output logic              MFC,
    output logic              addr_err,
    output logic              busy
);

    if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_bad_wait_states
        $error("mem_interface: WAIT_STATES must be in 0..15");
    end

    localparam logic [WAIT_W-1:0] LP_WAIT = WAIT_W'(WAIT_STATES);

    state_t              r_state;
    logic [WAIT_W-1:0]   r_cnt;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_data;
    logic                r_mfc;
    logic                r_err;
    logic                r_busy;

    logic                w_in_range;
    logic                w_access;
    logic                w_ram_we;
    logic [DATA_W-1:0]   w_ram_rdata;

    // Address decode and the single-cycle access strobe
    always_comb begin
        w_in_range = (r_addr[ADDR_W-1:DEPTH_LOG2] == '0);
        w_access   = (r_state == ST_ACCESS) && (r_cnt == '0);
        if (w_access && (r_rw == RW_WRITE) && w_in_range) begin
            w_ram_we = 1'b1;
        end else begin
            w_ram_we = 1'b0;
        end
    end

    mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (r_addr[DEPTH_LOG2-1:0]),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Request FSM: capture, wait-state countdown, access, handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rw    <= RW_READ;
            r_addr  <= '0;
            r_wdata <= '0;
            r_data  <= '0;
            r_mfc   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Enable) begin
                        r_rw    <= RW;
                        r_addr  <= Address;
                        r_wdata <= DataIn;
                        r_cnt   <= LP_WAIT;
                        r_busy  <= 1'b1;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - {{(WAIT_W-1){1'b0}}, 1'b1};
                    end else begin
                        // Out-of-range reads return zero; writes are gated by w_ram_we
                        if (r_rw == RW_READ) begin
                            r_data <= w_in_range ? w_ram_rdata : '0;
                        end
                        r_mfc   <= 1'b1;
                        r_err   <= ~w_in_range;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Stay complete until the requester drops Enable
                    if (!Enable) begin
                        r_mfc   <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_mfc   <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign DataToMDR = r_data;
    assign MFC       = r_mfc;
    assign addr_err  = r_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_interface.sv
module tb_mem_interface;

    logic        clk;
    logic        reset;

    // DUT A: WAIT_STATES = 2
    logic        a_en, a_rw;
    logic [15:0] a_addr, a_din, a_dout;
    logic        a_mfc, a_err, a_busy;

    // DUT B: WAIT_STATES = 0
    logic        b_en, b_rw;
    logic [15:0] b_addr, b_din, b_dout;
    logic        b_mfc, b_err, b_busy;

    int n_cmp;
    int n_err;

    mem_interface #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .WAIT_STATES(2)) u_dut_a (
        .clk(clk), .reset(reset), .Enable(a_en), .RW(a_rw), .Address(a_addr),
        .DataIn(a_din), .DataToMDR(a_dout), .MFC(a_mfc), .addr_err(a_err), .busy(a_busy)
    );

    mem_interface #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .WAIT_STATES(0)) u_dut_b (
        .clk(clk), .reset(reset), .Enable(b_en), .RW(b_rw), .Address(b_addr),
        .DataIn(b_din), .DataToMDR(b_dout), .MFC(b_mfc), .addr_err(b_err), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full four-phase transaction on DUT A; expects MFC WAIT_STATES+1 edges after capture
    task automatic txn_a(input logic rw, input logic [15:0] addr, input logic [15:0] din,
                         input logic [15:0] exp_data, input logic exp_err, input string name);
        int n;
        a_en = 1'b1; a_rw = rw; a_addr = addr; a_din = din;
        tick();                       // edge N: capture
        n = 0;
        while ((a_mfc !== 1'b1) && (n < 20)) begin
            tick();
            n++;
        end
        chk({name, "_latency"}, n, 3);
        chk({name, "_data"}, a_dout, exp_data);
        chk({name, "_err"}, a_err, exp_err);
        a_en = 1'b0;
        tick();
        chk({name, "_mfc_clr"}, a_mfc, 1'b0);
        chk({name, "_busy_clr"}, a_busy, 1'b0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b0;
        a_en = 1'b0; a_rw = 1'b1; a_addr = 16'h0000; a_din = 16'h0000;
        b_en = 1'b0; b_rw = 1'b1; b_addr = 16'h0000; b_din = 16'h0000;

        vecs[0]  = '{1'b0, 16'h0005, 16'hBEEF, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 16'h0005, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2]  = '{1'b0, 16'h0010, 16'h1111, 16'hBEEF, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 16'h5555, 16'hBEEF, 1'b0};
        vecs[4]  = '{1'b0, 16'h0003, 16'h3333, 16'hBEEF, 1'b0};
        vecs[5]  = '{1'b0, 16'h0100, 16'hAAAA, 16'hBEEF, 1'b1};
        vecs[6]  = '{1'b1, 16'h0000, 16'h0000, 16'h5555, 1'b0};
        vecs[7]  = '{1'b1, 16'h0100, 16'h0000, 16'h0000, 1'b1};
        vecs[8]  = '{1'b0, 16'h00FF, 16'h7E7E, 16'h0000, 1'b0};
        vecs[9]  = '{1'b1, 16'h00FF, 16'h0000, 16'h7E7E, 1'b0};
        vecs[10] = '{1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
        vecs[11] = '{1'b1, 16'h0010, 16'h0000, 16'h1111, 1'b0};

        tick(); tick();
        chk("rst_a_mfc",  a_mfc,  1'b0);
        chk("rst_a_data", a_dout, 16'h0000);
        chk("rst_a_busy", a_busy, 1'b0);
        chk("rst_a_err",  a_err,  1'b0);
        chk("rst_b_mfc",  b_mfc,  1'b0);
        chk("rst_b_busy", b_busy, 1'b0);
        reset = 1'b1;
        tick();

        // Table-driven transactions on DUT A
        for (int i = 0; i < 12; i++) begin
            txn_a(vecs[i].rw, vecs[i].addr, vecs[i].din, vecs[i].exp_data,
                  vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a write to 0x0010 aborts it
        a_en = 1'b1; a_rw = 1'b0; a_addr = 16'h0010; a_din = 16'h2222;
        tick();                       // edge N
        chk("abort_busy_pre", a_busy, 1'b1);
        tick();                       // mid-ACCESS
        reset = 1'b0;
        #1;
        chk("abort_mfc",  a_mfc,  1'b0);
        chk("abort_data", a_dout, 16'h0000);
        chk("abort_busy", a_busy, 1'b0);
        a_en = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        txn_a(1'b1, 16'h0010, 16'h0000, 16'h1111, 1'b0, "abort_readback");

        // Hold Enable after MFC; change inputs during ACCESS
        a_en = 1'b1; a_rw = 1'b1; a_addr = 16'h0010; a_din = 16'h0000;
        tick();                       // edge N
        a_addr = 16'h0005; a_rw = 1'b0; a_din = 16'hDEAD;
        tick(); tick();
        chk("hold_mfc_early", a_mfc, 1'b0);
        tick();                       // N+3
        chk("hold_mfc_rise", a_mfc, 1'b1);
        chk("hold_captured", a_dout, 16'h1111);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("hold_mfc_%0d", k), a_mfc, 1'b1);
        end
        chk("hold_busy", a_busy, 1'b1);
        a_en = 1'b0;
        tick();
        chk("hold_mfc_clr", a_mfc, 1'b0);
        txn_a(1'b1, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, "hold_no_write");

        // Enable high for a single edge on a read of 0x0003
        a_en = 1'b1; a_rw = 1'b1; a_addr = 16'h0003;
        tick();                       // edge N
        a_en = 1'b0;
        tick();
        chk("early_n1", a_mfc, 1'b0);
        tick();
        chk("early_n2", a_mfc, 1'b0);
        tick();
        chk("early_n3_mfc",  a_mfc,  1'b1);
        chk("early_n3_data", a_dout, 16'h3333);
        tick();
        chk("early_n4_mfc",  a_mfc,  1'b0);
        chk("early_n4_busy", a_busy, 1'b0);
        tick();
        chk("early_n5_mfc",  a_mfc,  1'b0);
        chk("early_n5_data", a_dout, 16'h3333);

        // DUT B with zero wait states
        b_en = 1'b1; b_rw = 1'b0; b_addr = 16'h0000; b_din = 16'h1234;
        tick();                       // edge N
        tick();                       // N+1
        chk("w0_write_mfc", b_mfc, 1'b1);
        chk("w0_write_data", b_dout, 16'h0000);
        b_en = 1'b0;
        tick();
        chk("w0_write_clr", b_mfc, 1'b0);
        b_en = 1'b1; b_rw = 1'b1;
        tick();                       // edge N
        chk("w0_read_pre", b_mfc, 1'b0);
        tick();                       // N+1
        chk("w0_read_mfc",  b_mfc,  1'b1);
        chk("w0_read_data", b_dout, 16'h1234);
        chk("w0_read_err",  b_err,  1'b0);
        b_en = 1'b0;
        tick();
        chk("w0_read_clr", b_mfc, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
